// File: rtl/pattern_loader.sv
// rtl/pattern_loader.sv - serial master that shifts BUFSIZE bytes into a pattern buffer and returns the old contents
module pattern_loader #(
  parameter int BUFSIZE = 27,
  parameter int CLKDIV  = 4,
  parameter int ABITS   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ABITS-1:0] addr,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [7:0]       dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             sin,
  input  logic             sout,
  output logic             ssel,
  output logic [ABITS-1:0] saddr
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BW = $clog2(BUFSIZE + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [BW-1:0] BUF_LAST = BW'(BUFSIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FETCH, S_LOW, S_HIGH, S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [BW-1:0]    byte_q, byte_d;
  logic [6:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             sclk_q, sclk_d;
  logic             sin_q, sin_d;
  logic             ssel_q, ssel_d;
  logic [ABITS-1:0] saddr_q, saddr_d;
  logic             din_ready_q, din_ready_d;
  logic [7:0]       dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_last;

  assign div_last = (div_q >= DIV_LAST);

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    byte_d       = byte_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    sclk_d       = sclk_q;
    sin_d        = sin_q;
    ssel_d       = ssel_q;
    saddr_d      = saddr_q;
    din_ready_d  = din_ready_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          saddr_d = addr;
          busy_d  = 1'b1;
          ssel_d  = 1'b1;
          div_d   = '0;
          byte_d  = '0;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (div_last) begin
          div_d       = '0;
          din_ready_d = 1'b1;
          state_d     = S_FETCH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_FETCH: begin
        // The handshake cycle already counts as the first low cycle of bit 7,
        // so an unstalled stream costs no extra cycles per byte.
        if (din_valid && din_ready_q) begin
          tx_d        = din[6:0];
          bit_d       = 3'd7;
          sin_d       = din[7];
          din_ready_d = 1'b0;
          div_d       = DW'(1);
          state_d     = S_LOW;
        end
      end

      S_LOW: begin
        if (div_last) begin
          rx_d    = {rx_q[6:0], sout};
          sclk_d  = 1'b1;
          div_d   = '0;
          state_d = S_HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_HIGH: begin
        if (div_last) begin
          sclk_d = 1'b0;
          div_d  = '0;
          if (bit_q != 3'd0) begin
            bit_d   = bit_q - 1'b1;
            sin_d   = tx_q[6];
            tx_d    = {tx_q[5:0], 1'b0};
            state_d = S_LOW;
          end else begin
            dout_d       = rx_q;
            dout_valid_d = 1'b1;
            byte_d       = byte_q + 1'b1;
            if (byte_q == BUF_LAST) begin
              state_d = S_HOLD;
            end else begin
              din_ready_d = 1'b1;
              state_d     = S_FETCH;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (div_last) begin
          ssel_d  = 1'b0;
          sin_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          div_d   = '0;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      bit_q        <= '0;
      byte_q       <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      sclk_q       <= 1'b0;
      sin_q        <= 1'b0;
      ssel_q       <= 1'b0;
      saddr_q      <= '0;
      din_ready_q  <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      sclk_q       <= sclk_d;
      sin_q        <= sin_d;
      ssel_q       <= ssel_d;
      saddr_q      <= saddr_d;
      din_ready_q  <= din_ready_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign sclk       = sclk_q;
  assign sin        = sin_q;
  assign ssel       = ssel_q;
  assign saddr      = saddr_q;
  assign din_ready  = din_ready_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pattern_loader.sv
// tb/tb_pattern_loader.sv - randomized load/readback bench for pattern_loader with a byte-level buffer model
module tb_pattern_loader;

  localparam int BUFSIZE = 27;
  localparam int CLKDIV  = 4;
  localparam int ABITS   = 3;
  localparam int NBITS   = 8 * BUFSIZE;
  localparam int T_LOAD  = CLKDIV * (2 + 16 * BUFSIZE);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [ABITS-1:0] addr = '0;
  logic [7:0]       din = '0;
  logic             din_valid = 1'b0;
  logic             din_ready;
  logic [7:0]       dout;
  logic             dout_valid;
  logic             busy;
  logic             done;
  logic             sclk;
  logic             sin;
  logic             sout;
  logic             ssel;
  logic [ABITS-1:0] saddr;

  pattern_loader #(.BUFSIZE(BUFSIZE), .CLKDIV(CLKDIV), .ABITS(ABITS)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done),
    .sclk(sclk), .sin(sin), .sout(sout), .ssel(ssel), .saddr(saddr)
  );

  always #5 clk = ~clk;

  // Buffer bank: each buffer is a shift chain, MSB leaves first on sout.
  logic [NBITS-1:0] bank [8];
  initial for (int b = 0; b < 8; b++) bank[b] = {BUFSIZE{8'hA5}};
  always @(posedge sclk) if (ssel) bank[saddr] <= {bank[saddr][NBITS-2:0], sin};
  assign sout = bank[saddr][NBITS-1];

  // Reference model: contents of each buffer as plain byte arrays.
  logic [7:0] ref_mem [8][BUFSIZE];
  logic [7:0] ref_prev [BUFSIZE];
  logic [7:0] tx_bytes [BUFSIZE];

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;
  int rises, dones, saddr_bad, ssel_bad, gap_bad, ssel_on, bad_sclk;
  logic [ABITS-1:0] exp_addr = '0;
  logic [7:0] rb_q [$];
  logic prev_sclk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sclk && !prev_sclk) rises++;
    if (sclk && !ssel) bad_sclk++;
    if (ssel) ssel_on++;
    if (busy && saddr !== exp_addr) saddr_bad++;
    if (busy && ssel !== 1'b1) ssel_bad++;
    if (dout_valid) rb_q.push_back(dout);
    if (done) dones++;
    prev_sclk = sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rises = 0; dones = 0; saddr_bad = 0; ssel_bad = 0; gap_bad = 0; ssel_on = 0; bad_sclk = 0;
    rb_q.delete();
  endtask

  task automatic do_load(input logic [ABITS-1:0] a, input int stall_before, input int stall_len,
                         input int restart_at, input int rst_at, output int dur, output bit aborted);
    int idx, stall_cnt, t_busy;
    bit restarted, finished, hs;
    @(negedge clk);
    exp_addr = a;
    clear_mon();
    for (int k = 0; k < BUFSIZE; k++) ref_prev[k] = ref_mem[a][k];
    start = 1'b1; addr = a;
    @(negedge clk);
    start = 1'b0; addr = 3'($urandom);
    t_busy = cyc;
    idx = 0; stall_cnt = 0; restarted = 0; finished = 0; aborted = 0; dur = -1;
    for (int n = 0; n < 20000 && !finished; n++) begin
      if (done) begin
        finished = 1; dur = cyc - t_busy;
      end else if (rst_at >= 0 && idx == rst_at + 1 && sclk) begin
        rst = 1'b1; din_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_ssel", 32'(ssel), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        aborted = 1; finished = 1;
      end else begin
        start = (!restarted && idx == restart_at);
        if (start) begin restarted = 1; addr = 3'd2; end
        else addr = 3'($urandom);
        if (idx == stall_before && din_ready && stall_cnt < stall_len) begin
          din_valid = 1'b0;
          // the first gap cycle still carries the previous byte's readback pulse
          if (sclk !== 1'b0 || ssel !== 1'b1 || (stall_cnt > 0 && dout_valid !== 1'b0)) gap_bad++;
          stall_cnt++;
        end else begin
          din_valid = (idx < BUFSIZE);
          din = (idx < BUFSIZE) ? tx_bytes[idx] : 8'($urandom);
        end
        hs = din_valid && din_ready;
        @(posedge clk);
        if (hs) idx++;
        @(negedge clk);
      end
    end
    din_valid = 1'b0; start = 1'b0;
    check("load_finished", 32'(finished), 32'd1);
  endtask

  task automatic check_result(input logic [ABITS-1:0] a, input string tag);
    check({tag, "_rb_count"}, 32'(rb_q.size()), BUFSIZE);
    for (int k = 0; k < BUFSIZE; k++)
      check($sformatf("%s_rb%0d", tag, k), 32'((k < rb_q.size()) ? rb_q[k] : 8'hxx), 32'(ref_prev[k]));
    for (int k = 0; k < BUFSIZE; k++)
      check($sformatf("%s_mem%0d", tag, k), 32'(bank[a][8*(BUFSIZE-1-k) +: 8]), 32'(tx_bytes[k]));
    for (int k = 0; k < BUFSIZE; k++) ref_mem[a][k] = tx_bytes[k];
    check({tag, "_rises"}, rises, 8 * BUFSIZE);
    check({tag, "_saddr"}, saddr_bad, 0);
    check({tag, "_ssel"}, ssel_bad, 0);
    check({tag, "_sclk_sel"}, bad_sclk, 0);
  endtask

  int dur;
  bit ab;

  initial begin
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < BUFSIZE; k++) ref_mem[b][k] = 8'hA5;

    // reset, then a long idle stretch
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({sclk, sin, ssel, saddr, din_ready, dout, dout_valid, busy, done}), 32'd0);
    rst = 1'b0;
    clear_mon();
    repeat (50) @(negedge clk);
    check("idle_rises", rises, 0);
    check("idle_ssel", ssel_on, 0);
    check("idle_busy", 32'(busy), 32'd0);

    // basic load: counting bytes, old contents 0xA5
    for (int k = 0; k < BUFSIZE; k++) tx_bytes[k] = 8'(k);
    do_load(3'd5, -1, 0, -1, -1, dur, ab);
    check("basic_time", dur, T_LOAD);
    repeat (3) @(negedge clk);
    check("basic_dones", dones, 1);
    check_result(3'd5, "basic");

    // constant pattern, reads back the counting bytes
    for (int k = 0; k < BUFSIZE; k++) tx_bytes[k] = 8'h3C;
    do_load(3'd5, -1, 0, -1, -1, dur, ab);
    check("const_time", dur, T_LOAD);
    check_result(3'd5, "const");

    // random data with a 37-cycle stall before byte 10
    for (int k = 0; k < BUFSIZE; k++) tx_bytes[k] = 8'($urandom);
    do_load(3'd5, 10, 37, -1, -1, dur, ab);
    check("stall_time", dur, T_LOAD + 37);
    check("stall_gap", gap_bad, 0);
    check_result(3'd5, "stall");

    // start again mid-load with another address is ignored
    for (int k = 0; k < BUFSIZE; k++) tx_bytes[k] = 8'($urandom);
    do_load(3'd5, -1, 0, 4, -1, dur, ab);
    repeat (30) @(negedge clk);
    check("restart_dones", dones, 1);
    check("restart_busy", 32'(busy), 32'd0);
    check_result(3'd5, "restart");

    // reset during byte 13 high phase aborts the load
    for (int k = 0; k < BUFSIZE; k++) tx_bytes[k] = 8'($urandom);
    do_load(3'd3, -1, 0, -1, 13, dur, ab);
    check("abort_taken", 32'(ab), 32'd1);
    repeat (40) @(negedge clk);
    check("abort_dones", dones, 0);
    check("abort_rises_after", 32'(sclk | ssel | busy), 32'd0);

    // a following load to buffer 1 completes normally
    for (int k = 0; k < BUFSIZE; k++) tx_bytes[k] = 8'($urandom);
    do_load(3'd1, -1, 0, -1, -1, dur, ab);
    check("post_abort_time", dur, T_LOAD);
    repeat (3) @(negedge clk);
    check("post_abort_dones", dones, 1);
    check_result(3'd1, "post_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
